// File: rtl/tmds_stream_encoder.sv
// tmds_stream_encoder: CHANNELS-lane pipelined TMDS encoder with per-lane disparity; `TMDS_HDMI_PREAMBLE_EN adds HDMI preamble/guard bands
module tmds_stream_encoder #(
  parameter int CHANNELS = 3,
  parameter int CTRL_CH = 0
) (
  input  logic                    pix_clk,
  input  logic                    rst,
  input  logic [CHANNELS*8-1:0]   rgb_data,
  input  logic                    hs,
  input  logic                    vs,
  input  logic                    de,
  output logic [CHANNELS*10-1:0]  tmds_word,
  output logic [9:0]              tmds_clk_word,
  output logic                    out_de,
  output logic                    sync_err
);
  typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, VIDEO} state_t;
  state_t st, st_nxt;
  logic [CHANNELS*8-1:0] pd;
  logic p_de, p_hs, p_vs;
  logic [8:0] s1_qm [CHANNELS];
  logic s1_de, s1_hs, s1_vs;
  logic [9:0] word [CHANNELS];
  logic [9:0] word_nxt [CHANNELS];
  logic signed [4:0] cnt [CHANNELS];
  logic signed [4:0] cnt_nxt [CHANNELS];
  function automatic logic [9:0] ctrl_word(input logic [1:0] c);
    return c == 2'b00 ? 10'h354 : c == 2'b01 ? 10'h0AB : c == 2'b10 ? 10'h154 : 10'h2AB;
  endfunction
  function automatic logic [8:0] qm_of(input logic [7:0] d);
    logic x;
    logic [8:0] q;
    x = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = x ^ q[i-1] ^ d[i];
    q[8] = ~x;
    return q;
  endfunction
  function automatic logic [14:0] encode(input logic [8:0] q, input logic signed [4:0] c);
    logic signed [4:0] diff, b, n;
    logic [9:0] w;
    diff = 5'(2 * $countones(q[7:0]) - 8);
    b = q[8] ? 5'sd2 : 5'sd0;
    if (c == 5'sd0 || diff == 5'sd0) begin
      w = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      n = c + (q[8] ? diff : -diff);
    end else if ((c > 5'sd0 && diff > 5'sd0) || (c < 5'sd0 && diff < 5'sd0)) begin
      w = {1'b1, q[8], ~q[7:0]};
      n = c + b - diff;
    end else begin
      w = {1'b0, q[8], q[7:0]};
      n = c + diff - (5'sd2 - b);
    end
    return {n, w};
  endfunction
  assign tmds_clk_word = 10'b1111100000;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign tmds_word[10*g +: 10] = word[g];
  end
`ifdef TMDS_HDMI_PREAMBLE_EN
  logic [CHANNELS*8+2:0] dl [10];
  logic [3:0] ph, ph_nxt;
  logic rise;
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      dl <= '{default: '0};
    end else begin
      dl[0] <= {de, vs, hs, rgb_data};
      for (int i = 1; i < 10; i++) dl[i] <= dl[i-1];
    end
  end
  assign {p_de, p_vs, p_hs, pd} = dl[9];
  assign rise = de && !dl[0][CHANNELS*8+2];
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      st <= CTRL;
      ph <= 4'd0;
      sync_err <= 1'b0;
      out_de <= 1'b0;
    end else begin
      st <= st_nxt;
      ph <= ph_nxt;
      sync_err <= rise && st != CTRL;
      out_de <= s1_de;
    end
  end
  // the preamble/guard counter runs from the raw de edge so the guard band ends exactly as delayed video arrives
  always_comb begin
    ph_nxt = (st == PREAMBLE || st == GUARD) ? ph + 4'd1 : 4'd0;
    st_nxt = st == CTRL ? (rise ? PREAMBLE : s1_de ? VIDEO : CTRL) :
             st == PREAMBLE ? (ph == 4'd7 ? GUARD : PREAMBLE) :
             st == GUARD ? (ph == 4'd9 ? VIDEO : GUARD) :
             (s1_de ? VIDEO : CTRL);
  end
`else
  assign {p_de, p_vs, p_hs, pd} = {de, vs, hs, rgb_data};
  always_ff @(posedge pix_clk) begin
    if (rst) st <= CTRL;
    else st <= st_nxt;
  end
  always_comb st_nxt = s1_de ? VIDEO : CTRL;
  assign out_de = st == VIDEO;
  assign sync_err = 1'b0;
`endif
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      {cnt_nxt[k], word_nxt[k]} = encode(s1_qm[k], cnt[k]);
      if (!s1_de) begin
        cnt_nxt[k] = '0;
        word_nxt[k] = k == CTRL_CH ? ctrl_word({s1_vs, s1_hs}) : 10'h354;
`ifdef TMDS_HDMI_PREAMBLE_EN
        if (st == PREAMBLE && k == 1) word_nxt[k] = 10'h0AB;
        if (st == GUARD && k < 3) word_nxt[k] = k == 1 ? 10'h133 : 10'h2CC;
`endif
      end
    end
  end
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      s1_de <= 1'b0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_qm <= '{default: '0};
      word <= '{default: 10'h354};
      cnt <= '{default: '0};
    end else begin
      s1_de <= p_de;
      s1_hs <= p_hs;
      s1_vs <= p_vs;
      for (int k = 0; k < CHANNELS; k++) s1_qm[k] <= qm_of(pd[8*k +: 8]);
      word <= word_nxt;
      cnt <= cnt_nxt;
    end
  end
endmodule
